uart_rx: RTL and testbench

UART receiver: the receive counterpart of the serial interface's transmitter, sharing the same `CLKS_PER_BIT` baud convention. It takes the asynchronous serial line from the pin, synchronizes it, and detects and validates the start bit. It samples 8 data bits LSB-first at mid-bit, checks the stop bit, and presents each received byte on a valid/ready output register to the host-side logic. Framing, overrun and (optionally) parity errors are reported as one-cycle pulses.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_sync2.sv | 28 ++
 rtl/uart_rx.sv | 193 +++++++++++++++++++
 tb/tb_uart_rx.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame width, line idle level.
package uart_pkg;

   localparam int unsigned UART_DATA_BITS  = 8;
   localparam logic        UART_IDLE_LEVEL = 1'b1;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4,
      BREAK  = 3'd5
   } uart_rx_state_t;

endpackage

// File: rtl/uart_sync2.sv
// Generic two-flop synchronizer for an asynchronous pin; RST_VAL sets the
// level both flops take in reset.
module uart_sync2 #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   // Two-stage capture of the asynchronous input.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8 data bits LSB-first sampled at mid-bit, valid/ready byte
// output, one-cycle framing/overrun/parity error pulses.
// Optional even parity bit when UART_RX_PARITY_EN is defined (default 8N1).
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 868
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      rx_uart,
   input  logic                      rx_ready,
   output logic [UART_DATA_BITS-1:0] rx_byte,
   output logic                      rx_valid,
   output logic                      rx_busy,
   output logic                      rx_frame_err,
   output logic                      rx_overrun,
   output logic                      rx_parity_err
);

   localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
   localparam int unsigned IDX_W = $clog2(UART_DATA_BITS);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(UART_DATA_BITS - 1);

   logic                      rx_s;
   uart_rx_state_t            state_q;
   logic [CNT_W-1:0]          cnt_q;
   logic [IDX_W-1:0]          idx_q;
   logic [UART_DATA_BITS-1:0] shift_q;
   logic [UART_DATA_BITS-1:0] byte_q;
   logic                      valid_q;
   logic                      busy_q;
   logic                      frame_err_q;
   logic                      overrun_q;
`ifdef UART_RX_PARITY_EN
   logic                      par_pend_q;
   logic                      par_err_q;
`endif

   uart_sync2 #(
      .RST_VAL (UART_IDLE_LEVEL)
   ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (rx_uart),
      .q_o   (rx_s)
   );

   // Frame FSM with bit timing, byte delivery and error pulse generation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         idx_q       <= '0;
         shift_q     <= '0;
         byte_q      <= '0;
         valid_q     <= 1'b0;
         busy_q      <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_pend_q  <= 1'b0;
         par_err_q   <= 1'b0;
`endif
      end else begin
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_err_q   <= 1'b0;
`endif
         // Acceptance; a delivery below in the same cycle overrides this.
         if (valid_q && rx_ready) begin
            valid_q <= 1'b0;
         end

         case (state_q)
            IDLE: begin
               cnt_q <= '0;
               idx_q <= '0;
               if (rx_s != UART_IDLE_LEVEL) begin
                  state_q <= START;
                  busy_q  <= 1'b1;
               end
            end

            START: begin
               if (cnt_q == CNT_HALF) begin
                  cnt_q <= '0;
                  if (rx_s == UART_IDLE_LEVEL) begin
                     // Line went back high before mid-start: treat as a glitch.
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
                  end else begin
                     state_q <= DATA;
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end

            DATA: begin
               if (cnt_q == CNT_LAST) begin
                  cnt_q   <= '0;
                  shift_q <= {rx_s, shift_q[UART_DATA_BITS-1:1]};
                  idx_q   <= idx_q + IDX_W'(1);
                  if (idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                     state_q <= PARITY;
`else
                     state_q <= STOP;
`endif
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end

`ifdef UART_RX_PARITY_EN
            PARITY: begin
               if (cnt_q == CNT_LAST) begin
                  cnt_q   <= '0;
                  state_q <= STOP;
                  if (rx_s != (^shift_q)) begin
                     par_pend_q <= 1'b1;
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
`endif

            STOP: begin
               if (cnt_q == CNT_LAST) begin
                  cnt_q <= '0;
`ifdef UART_RX_PARITY_EN
                  par_pend_q <= 1'b0;
`endif
                  if (rx_s == UART_IDLE_LEVEL) begin
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
                     if (par_pend_q) begin
                        par_err_q <= 1'b1;
                     end else
`endif
                     if (!valid_q || rx_ready) begin
                        byte_q  <= shift_q;
                        valid_q <= 1'b1;
                     end else begin
                        overrun_q <= 1'b1;
                     end
                  end else begin
                     frame_err_q <= 1'b1;
                     state_q     <= BREAK;
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end

            BREAK: begin
               // Hold off until the line returns high so a stuck-low line
               // does not decode as a stream of zero bytes.
               if (rx_s == UART_IDLE_LEVEL) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            end

            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               cnt_q   <= '0;
               idx_q   <= '0;
            end
         endcase
      end
   end

   assign rx_byte      = byte_q;
   assign rx_valid     = valid_q;
   assign rx_busy      = busy_q;
   assign rx_frame_err = frame_err_q;
   assign rx_overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
   assign rx_parity_err = par_err_q;
`else
   assign rx_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at CLKS_PER_BIT=8 with a byte scoreboard.
module tb_uart_rx;

   localparam int C  = 8;
   localparam int H  = (C - 1) / 2;
`ifdef UART_RX_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif
   // Bits up to and including stop, counted from the start bit.
   localparam int NB  = PAR_EN ? 10 : 9;
   // Pin start edge -> rx_valid visible: 2 sync + 1 to START + H + 1 + NB*C - 1 + 1.
   localparam int LAT = 4 + H + NB * C;

   logic       clk      = 1'b0;
   logic       rst_n    = 1'b0;
   logic       rx_uart  = 1'b1;
   logic       rx_ready = 1'b1;
   logic [7:0] rx_byte;
   logic       rx_valid;
   logic       rx_busy;
   logic       rx_frame_err;
   logic       rx_overrun;
   logic       rx_parity_err;

   uart_rx #(
      .CLKS_PER_BIT (C)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .rx_uart       (rx_uart),
      .rx_ready      (rx_ready),
      .rx_byte       (rx_byte),
      .rx_valid      (rx_valid),
      .rx_busy       (rx_busy),
      .rx_frame_err  (rx_frame_err),
      .rx_overrun    (rx_overrun),
      .rx_parity_err (rx_parity_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_tests     = 0;
   int n_fail      = 0;
   int rise_cnt    = 0;
   int rise_cyc    = 0;
   int start_cyc   = 0;
   int frame_cnt   = 0;
   int overrun_cnt = 0;
   int parity_cnt  = 0;
   logic [7:0] exp_q[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drive_bit(input logic v, input int nbits);
      rx_uart = v;
      idle(nbits * C);
   endtask

   task automatic send_head(input logic [7:0] b, input logic p);
      start_cyc = cyc;
      drive_bit(1'b0, 1);
      for (int i = 0; i < 8; i++) drive_bit(b[i], 1);
      if (PAR_EN) drive_bit(p, 1);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic p);
      send_head(b, p);
      drive_bit(1'b1, 1);
   endtask

   // Output monitor: scoreboard pop on handshake, byte stability, pulse counts.
   logic       valid_prev = 1'b0;
   logic       acc_prev   = 1'b0;
   logic [7:0] byte_prev  = 8'h00;
   always @(negedge clk) begin
      if (rst_n) begin
         if (rx_valid && !valid_prev) begin
            rise_cnt++;
            rise_cyc = cyc;
         end
         if (valid_prev && rx_valid && !acc_prev)
            chk("byte_stable", 32'(rx_byte), 32'(byte_prev));
         if (rx_valid && rx_ready) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               assert (exp_q.size() != 0) else begin
                  n_fail++;
                  $error("FAIL sb_unexpected: observed byte %0h expected none", rx_byte);
               end
            end else begin
               chk("sb_byte", 32'(rx_byte), 32'(exp_q.pop_front()));
            end
         end
         frame_cnt   += int'(rx_frame_err);
         overrun_cnt += int'(rx_overrun);
         parity_cnt  += int'(rx_parity_err);
         valid_prev = rx_valid;
         acc_prev   = rx_valid && rx_ready;
         byte_prev  = rx_byte;
      end else begin
         valid_prev = 1'b0;
         acc_prev   = 1'b0;
      end
   end

   initial begin
      // Reset values
      idle(3);
      chk("rst_byte",   32'(rx_byte),       32'h00);
      chk("rst_valid",  32'(rx_valid),      32'h0);
      chk("rst_busy",   32'(rx_busy),       32'h0);
      chk("rst_frame",  32'(rx_frame_err),  32'h0);
      chk("rst_ovr",    32'(rx_overrun),    32'h0);
      chk("rst_par",    32'(rx_parity_err), 32'h0);
      rst_n = 1'b1;
      idle(4);

      // Single byte and output latency
      exp_q.push_back(8'hA5);
      send_frame(8'hA5, ^8'hA5);
      idle(2);
      chk("single_rise",  32'(rise_cnt),             32'd1);
      chk("latency",      32'(rise_cyc - start_cyc), 32'(LAT));
      chk("single_frame", 32'(frame_cnt),            32'd0);
      chk("single_idle",  32'(rx_busy),              32'h0);

      // Glitch: 3-cycle low pulse
      rx_uart = 1'b0;
      idle(3);
      rx_uart = 1'b1;
      idle(1);
      chk("glitch_busy", 32'(rx_busy), 32'h1);
      idle(2 * C);
      chk("glitch_idle",  32'(rx_busy),   32'h0);
      chk("glitch_rise",  32'(rise_cnt),  32'd1);
      chk("glitch_frame", 32'(frame_cnt), 32'd0);

      // Framing error: stop held low for 20 bit times
      send_head(8'h3C, ^8'h3C);
      drive_bit(1'b0, 10);
      chk("brk_busy",  32'(rx_busy),   32'h1);
      chk("brk_frame", 32'(frame_cnt), 32'd1);
      drive_bit(1'b0, 10);
      drive_bit(1'b1, 2);
      chk("brk_idle", 32'(rx_busy),  32'h0);
      chk("brk_rise", 32'(rise_cnt), 32'd1);
      exp_q.push_back(8'h55);
      send_frame(8'h55, ^8'h55);
      idle(2);
      chk("post_brk_rise", 32'(rise_cnt), 32'd2);

      // Overrun: two back-to-back bytes with rx_ready low
      rx_ready = 1'b0;
      exp_q.push_back(8'h11);
      send_frame(8'h11, ^8'h11);
      send_frame(8'h22, ^8'h22);
      idle(2);
      chk("ovr_cnt",   32'(overrun_cnt), 32'd1);
      chk("ovr_valid", 32'(rx_valid),    32'h1);
      chk("ovr_byte",  32'(rx_byte),     32'h11);
      chk("ovr_rise",  32'(rise_cnt),    32'd3);
      rx_ready = 1'b1;
      idle(1);
      chk("ovr_drop", 32'(rx_valid), 32'h0);

      // Reset during data bit 4 of 0xF0
      drive_bit(1'b0, 1);
      for (int i = 0; i < 4; i++) drive_bit(1'b0, 1);
      rx_uart = 1'b1;
      idle(C / 2);
      chk("mid_busy", 32'(rx_busy), 32'h1);
      rst_n = 1'b0;
      idle(2);
      chk("mrst_byte",  32'(rx_byte),       32'h00);
      chk("mrst_valid", 32'(rx_valid),      32'h0);
      chk("mrst_busy",  32'(rx_busy),       32'h0);
      chk("mrst_frame", 32'(rx_frame_err),  32'h0);
      chk("mrst_ovr",   32'(rx_overrun),    32'h0);
      chk("mrst_par",   32'(rx_parity_err), 32'h0);
      rst_n = 1'b1;
      drive_bit(1'b1, 5);
      exp_q.push_back(8'h81);
      send_frame(8'h81, ^8'h81);
      idle(2);
      chk("post_rst_rise", 32'(rise_cnt), 32'd4);

`ifdef UART_RX_PARITY_EN
      // Even parity: correct then wrong parity bit
      exp_q.push_back(8'h07);
      send_frame(8'h07, 1'b1);
      idle(2);
      chk("par_ok_rise", 32'(rise_cnt), 32'd5);
      send_frame(8'h07, 1'b0);
      idle(2);
      chk("par_bad_cnt",  32'(parity_cnt), 32'd1);
      chk("par_bad_rise", 32'(rise_cnt),   32'd5);
`endif

      // Totals
      idle(4);
      chk("sb_empty",    32'(exp_q.size()), 32'd0);
      chk("frame_total", 32'(frame_cnt),    32'd1);
      chk("ovr_total",   32'(overrun_cnt),  32'd1);
`ifdef UART_RX_PARITY_EN
      chk("par_total",   32'(parity_cnt),   32'd1);
`else
      chk("par_total",   32'(parity_cnt),   32'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
